// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU-to-accelerator bus interface: page map
// helpers (functions of the SRAM bank count), CTRL page register offsets,
// command bits and the control FSM state encoding.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // CTRL page byte offsets
  localparam int CTRL_CMD    = 'h000;
  localparam int CTRL_STATUS = 'h004;
  localparam int CTRL_ARGMAX = 'h008;
  localparam int CTRL_MAXVAL = 'h00C;

  // CTRL_CMD write bits
  localparam int CMD_START_BIT = 0;
  localparam int CMD_CLEAR_BIT = 1;

  // Pages 0..n_sram-1 are weight banks; page n_sram+1 is deliberately a hole.
  function automatic int page_bias(input int n_sram);
    return n_sram;
  endfunction

  function automatic int page_image(input int n_sram);
    return n_sram + 2;
  endfunction

  function automatic int page_result(input int n_sram);
    return n_sram + 3;
  endfunction

  function automatic int page_ctrl(input int n_sram);
    return n_sram + 4;
  endfunction

endpackage

// File: rtl/cpu_bus_if_result_argmax_scan.sv
// Sequential argmax over the result words, one word per cycle.
// Latency: start_scan loads word 0; scan_last asserts on the N_RESULT-th scan cycle.
// No backpressure: advances every cycle scan_en is high. argmax/maxval only
// update when a scan completes, so they hold the previous answer meanwhile.
// Ports: clk, rst_n, start_scan, scan_en, result (flattened) -> scan_last, argmax, maxval.
module result_argmax_scan #(
  parameter int N_RESULT = 46,
  parameter int DATA_W   = 32,
  parameter int IDX_W    = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_scan,
  input  logic                         scan_en,
  input  logic [N_RESULT*DATA_W-1:0]   result,
  output logic                         scan_last,
  output logic [IDX_W-1:0]             argmax,
  output logic [DATA_W-1:0]            maxval
);

  logic [DATA_W-1:0] words [N_RESULT];
  for (genvar g = 0; g < N_RESULT; g++) begin : g_unpack
    assign words[g] = result[g*DATA_W +: DATA_W];
  end

  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  cur_arg_q;
  logic [DATA_W-1:0] cur_max_q;
  logic [DATA_W-1:0] cur_word;
  logic              better;

  assign cur_word  = words[idx_q];
  // Strict compare keeps the lowest index on ties.
  assign better    = $signed(cur_word) > $signed(cur_max_q);
  assign scan_last = scan_en && (idx_q == IDX_W'(N_RESULT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      cur_arg_q <= '0;
      cur_max_q <= '0;
      argmax    <= '0;
      maxval    <= '0;
    end else if (start_scan) begin
      idx_q     <= '0;
      cur_arg_q <= '0;
      cur_max_q <= words[0];
    end else if (scan_en) begin
      if (!scan_last) begin
        idx_q <= idx_q + IDX_W'(1);
      end
      if (better) begin
        cur_max_q <= cur_word;
        cur_arg_q <= idx_q;
      end
      // Publish including the final word's comparison.
      if (scan_last) begin
        argmax <= better ? idx_q    : cur_arg_q;
        maxval <= better ? cur_word : cur_max_q;
      end
    end
  end

endmodule

// File: rtl/cpu_bus_if.sv
// CPU-to-accelerator bus interface: page decode to SRAM/bias/image selects,
// registered result/CTRL read mux, start/done FSM with argmax scanner.
// Latency: selects/write path and read data are registered (1 cycle).
// No backpressure: every CPU strobe is serviced in one cycle, reads always answer.
// Ports: CLK, RESET_X; CPU_WR/RD/ADR/WDATA -> CPU_RDATA/RVALID;
// SRAM_SEL, BIAS_SEL, IMAGE_SEL, SRAM_BIAS_IMG_WR, SRAM_WADR, SRAM_DATA;
// RESULT in; CORE_START out, CORE_DONE in.
module cpu_bus_if
  import cpu_bus_pkg::*;
#(
  parameter int N_SRAM   = 46,
  parameter int N_RESULT = 46,
  parameter int DATA_W   = 32,
  parameter int ADR_W    = 18,
  parameter int PAGE_W   = 12
) (
  input  logic                        CLK,
  input  logic                        RESET_X,
  input  logic                        CPU_WR,
  input  logic                        CPU_RD,
  input  logic [ADR_W-1:0]            CPU_ADR,
  input  logic [DATA_W-1:0]           CPU_WDATA,
  output logic [DATA_W-1:0]           CPU_RDATA,
  output logic                        CPU_RVALID,
  output logic [N_SRAM-1:0]           SRAM_SEL,
  output logic                        BIAS_SEL,
  output logic                        IMAGE_SEL,
  output logic                        SRAM_BIAS_IMG_WR,
  output logic [PAGE_W-3:0]           SRAM_WADR,
  output logic [DATA_W-1:0]           SRAM_DATA,
  input  logic [N_RESULT*DATA_W-1:0]  RESULT,
  output logic                        CORE_START,
  input  logic                        CORE_DONE
);

  localparam int PG_W  = ADR_W - PAGE_W;
  localparam int WA_W  = PAGE_W - 2;
  localparam int IDX_W = (N_RESULT > 1) ? $clog2(N_RESULT) : 1;

  localparam logic [PG_W-1:0] PG_BIAS   = PG_W'(page_bias(N_SRAM));
  localparam logic [PG_W-1:0] PG_IMAGE  = PG_W'(page_image(N_SRAM));
  localparam logic [PG_W-1:0] PG_RESULT = PG_W'(page_result(N_SRAM));
  localparam logic [PG_W-1:0] PG_CTRL   = PG_W'(page_ctrl(N_SRAM));

  logic [PG_W-1:0]   page;
  logic [PAGE_W-1:0] off;
  logic [WA_W-1:0]   word_off;

  assign page     = CPU_ADR[ADR_W-1:PAGE_W];
  assign off      = CPU_ADR[PAGE_W-1:0];
  assign word_off = CPU_ADR[PAGE_W-1:2];

  // ---------------- address decode ----------------
  logic [N_SRAM-1:0] sram_sel_d;
  logic              is_sram, is_bias, is_image;

  always_comb begin
    sram_sel_d = '0;
    for (int i = 0; i < N_SRAM; i++) begin
      if (page == PG_W'(i)) sram_sel_d[i] = 1'b1;
    end
  end

  assign is_sram  = (page < PG_W'(N_SRAM));
  assign is_bias  = (page == PG_BIAS);
  assign is_image = (page == PG_IMAGE);

  logic cmd_wr, start_req, clear_req;
  assign cmd_wr    = CPU_WR && (page == PG_CTRL) && (off == PAGE_W'(CTRL_CMD));
  assign start_req = cmd_wr && CPU_WDATA[CMD_START_BIT];
  assign clear_req = cmd_wr && CPU_WDATA[CMD_CLEAR_BIT];

  // ---------------- control FSM ----------------
  state_t            state_q, state_d;
  logic              core_start_d;
  logic              start_scan;
  logic              scan_en;
  logic              scan_last;
  logic [IDX_W-1:0]  argmax;
  logic [DATA_W-1:0] maxval;

  assign scan_en = (state_q == ST_SCAN);

  always_comb begin
    state_d      = state_q;
    core_start_d = 1'b0;
    start_scan   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          state_d      = ST_RUN;
          core_start_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (CORE_DONE) begin
          state_d    = ST_SCAN;
          start_scan = 1'b1;
        end
      end
      ST_SCAN: begin
        if (scan_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        // START takes priority when both bits are written together.
        if (start_req) begin
          state_d      = ST_RUN;
          core_start_d = 1'b1;
        end else if (clear_req) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  result_argmax_scan #(
    .N_RESULT (N_RESULT),
    .DATA_W   (DATA_W),
    .IDX_W    (IDX_W)
  ) u_scan (
    .clk        (CLK),
    .rst_n      (RESET_X),
    .start_scan (start_scan),
    .scan_en    (scan_en),
    .result     (RESULT),
    .scan_last  (scan_last),
    .argmax     (argmax),
    .maxval     (maxval)
  );

  // ---------------- read mux ----------------
  logic [DATA_W-1:0] res_word [N_RESULT];
  for (genvar g = 0; g < N_RESULT; g++) begin : g_res
    assign res_word[g] = RESULT[g*DATA_W +: DATA_W];
  end

  logic [DATA_W-1:0] status;
  logic [DATA_W-1:0] rdata_d;

  assign status = {{(DATA_W-4){1'b0}}, 2'(state_q), (state_q == ST_DONE),
                   (state_q == ST_RUN) || (state_q == ST_SCAN)};

  always_comb begin
    rdata_d = '0;
    if (page == PG_RESULT) begin
      if (word_off < WA_W'(N_RESULT)) rdata_d = res_word[word_off[IDX_W-1:0]];
    end else if (page == PG_CTRL) begin
      if (off == PAGE_W'(CTRL_STATUS))      rdata_d = status;
      else if (off == PAGE_W'(CTRL_ARGMAX)) rdata_d = {{(DATA_W-IDX_W){1'b0}}, argmax};
      else if (off == PAGE_W'(CTRL_MAXVAL)) rdata_d = maxval;
    end
  end

  // ---------------- output registers ----------------
  always_ff @(posedge CLK or negedge RESET_X) begin
    if (!RESET_X) begin
      state_q          <= ST_IDLE;
      CORE_START       <= 1'b0;
      CPU_RDATA        <= '0;
      CPU_RVALID       <= 1'b0;
      SRAM_SEL         <= '0;
      BIAS_SEL         <= 1'b0;
      IMAGE_SEL        <= 1'b0;
      SRAM_BIAS_IMG_WR <= 1'b0;
      SRAM_WADR        <= '0;
      SRAM_DATA        <= '0;
    end else begin
      state_q          <= state_d;
      CORE_START       <= core_start_d;
      CPU_RVALID       <= CPU_RD;
      if (CPU_RD) CPU_RDATA <= rdata_d;
      SRAM_SEL         <= sram_sel_d;
      BIAS_SEL         <= is_bias;
      IMAGE_SEL        <= is_image;
      SRAM_BIAS_IMG_WR <= CPU_WR && (is_sram || is_bias || is_image);
      SRAM_WADR        <= word_off;
      SRAM_DATA        <= CPU_WDATA;
    end
  end

endmodule
